// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   Data-memory access sequencer between the multi-cycle control FSM and a 64-bit
//   data memory. Takes one load/store at a time, presents doubleword-aligned
//   addresses, extracts/extends load lanes, does read-modify-write for
//   sub-doubleword stores and reports misaligned accesses as faults without
//   touching memory.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we, req_size    1 = store; size 00 byte, 01 half, 10 word, 11 double
//   req_unsigned        loads: 1 zero-extend, 0 sign-extend
//   req_addr, req_wdata byte address; right-justified store data
//   resp_valid          one-cycle completion pulse
//   resp_fault          completion was a misaligned fault
//   resp_rdata          extended load data (0 for stores and faults)
//   mem_addr            doubleword-aligned address
//   mem_wr, mem_wdata   one-cycle write strobe with full doubleword data
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_addr
module dmem_access_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_fault,
    output logic [63:0] resp_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    localparam logic [1:0] LatInit = 2'(MEM_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [2:0]  off_q, off_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        misaligned;
    logic [63:0] lane_mask;
    logic [5:0]  lane_shift;
    logic [63:0] rd_shift;
    logic [63:0] load_ext;
    logic [63:0] merged;

    // Offset must be a multiple of the access size.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    always_comb begin
        lane_mask = '1;
        case (size_q)
            2'b00:   lane_mask = 64'h0000_0000_0000_00ff;
            2'b01:   lane_mask = 64'h0000_0000_0000_ffff;
            2'b10:   lane_mask = 64'h0000_0000_ffff_ffff;
            default: lane_mask = '1;
        endcase
    end

    assign lane_shift = {off_q, 3'b000};
    assign rd_shift   = mem_rdata >> lane_shift;

    // Selected lanes moved down to bit 0, then sign/zero-extended.
    always_comb begin
        load_ext = rd_shift;
        case (size_q)
            2'b00:   load_ext = {{56{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_ext = {{48{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
            2'b10:   load_ext = {{32{~uns_q & rd_shift[31]}}, rd_shift[31:0]};
            default: load_ext = rd_shift;
        endcase
    end

    // Read-modify-write: replace only the addressed lanes, keep the rest.
    assign merged = (mem_rdata & ~(lane_mask << lane_shift))
                  | ((wdata_q & lane_mask) << lane_shift);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[2:0];
                    wdata_d = req_wdata;
                    addr_d  = {req_addr[63:3], 3'b000};
                    if (misaligned) begin
                        state_d = StResp;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else if (req_we && (req_size == 2'b11)) begin
                        // Full doubleword store needs no read.
                        state_d     = StWrite;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = StRead;
                        cnt_d   = LatInit;
                    end
                end
            end
            StRead: begin
                if (cnt_q == 2'd0) begin
                    if (we_q) begin
                        mem_wdata_d = merged;
                        state_d     = StWrite;
                    end else begin
                        rdata_d = load_ext;
                        fault_d = 1'b0;
                        state_d = StResp;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StWrite: begin
                fault_d = 1'b0;
                rdata_d = '0;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign mem_wr     = (state_q == StWrite);
    assign resp_fault = fault_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: instance 0 uses MEM_LAT=1, instance 1
// uses MEM_LAT=3. Each has a small memory model whose read data is only valid
// once the address has been stable for MEM_LAT cycles.
module tb_dmem_access_unit;

    typedef struct {
        logic        fault;
        logic [63:0] rdata;
        logic [63:0] addr;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [1:0]  req_size   [2];
    logic        req_uns    [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_fault [2];
    logic [63:0] resp_rdata [2];
    logic [63:0] mem_addr   [2];
    logic        mem_wr     [2];
    logic [63:0] mem_wdata  [2];
    logic [63:0] mem_rdata  [2];

    logic [63:0] mem  [2][32];
    logic [63:0] hist [2][3];
    logic        pre_we = 1'b0;
    int          pre_g = 0;
    logic [4:0]  pre_idx = '0;
    logic [63:0] pre_data = '0;

    resp_t rq [2][$];
    wr_t   wq [2][$];

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_access_unit #(.MEM_LAT((g == 0) ? 1 : 3)) u_dut (
            .clk          (clk),
            .reset        (rst_n[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_uns[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .resp_valid   (resp_valid[g]),
            .resp_fault   (resp_fault[g]),
            .resp_rdata   (resp_rdata[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wr       (mem_wr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g])
        );
    end

    // Memory model: writes on mem_wr, address history for the latency window.
    always @(posedge clk) begin
        if (pre_we) mem[pre_g][pre_idx] <= pre_data;
        for (int g = 0; g < 2; g++) begin
            if (mem_wr[g]) mem[g][mem_addr[g][7:3]] <= mem_wdata[g];
            hist[g][0] <= mem_addr[g];
            hist[g][1] <= hist[g][0];
            hist[g][2] <= hist[g][1];
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            logic ok;
            ok = 1'b1;
            for (int k = 0; k < ((g == 0) ? 0 : 2); k++) begin
                if (hist[g][k] != mem_addr[g]) ok = 1'b0;
            end
            mem_rdata[g] = ok ? mem[g][mem_addr[g][7:3]] : 64'hdead_beef_dead_beef;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a response or write.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (resp_valid[g]) begin
                if (rq[g].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resp inst %0d: got resp_valid at cycle %0d, expected none",
                             g, cyc);
                end else begin
                    resp_t e;
                    e = rq[g].pop_front();
                    chk($sformatf("resp_fault[%0d]", g), 64'(resp_fault[g]), 64'(e.fault));
                    chk($sformatf("resp_rdata[%0d]", g), resp_rdata[g], e.rdata);
                    chk($sformatf("mem_addr[%0d]", g), mem_addr[g], e.addr);
                    chk($sformatf("resp_cycle[%0d]", g), 64'(cyc), 64'(e.cyc));
                end
            end
            if (mem_wr[g]) begin
                if (wq[g].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_mem_wr inst %0d: got mem_wr at cycle %0d, expected none",
                             g, cyc);
                end else begin
                    wr_t w;
                    w = wq[g].pop_front();
                    chk($sformatf("wr_addr[%0d]", g), mem_addr[g], w.addr);
                    chk($sformatf("wr_data[%0d]", g), mem_wdata[g], w.data);
                    chk($sformatf("wr_cycle[%0d]", g), 64'(cyc), 64'(w.cyc));
                end
            end
        end
    end

    task automatic preload(input int g, input logic [4:0] idx, input logic [63:0] data);
        pre_g    = g;
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Issue one request; dresp/dwr are cycle offsets from the accept edge (dwr<0: no write).
    task automatic issue(input int g, input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic push,
                         input logic fault, input logic [63:0] rdata, input int dresp,
                         input int dwr, input logic [63:0] wrdata);
        int n;
        int a;
        n = 0;
        while (!req_ready[g] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready[g]) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout inst %0d: got req_ready=0 for 20 cycles, expected 1", g);
            return;
        end
        req_we[g]    = we;
        req_size[g]  = size;
        req_uns[g]   = uns;
        req_addr[g]  = addr;
        req_wdata[g] = wdata;
        req_valid[g] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
        a = cyc;
        if (push) begin
            rq[g].push_back('{fault, rdata, {addr[63:3], 3'b000}, a + dresp});
            if (dwr >= 0) wq[g].push_back('{{addr[63:3], 3'b000}, wrdata, a + dwr});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_n[g]     = 1'b0;
            req_valid[g] = 1'b0;
            req_we[g]    = 1'b0;
            req_size[g]  = 2'b00;
            req_uns[g]   = 1'b0;
            req_addr[g]  = '0;
            req_wdata[g] = '0;
        end
        #1;
        chk("rst_req_ready", 64'(req_ready[0]), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
        chk("rst_resp_fault", 64'(resp_fault[0]), 64'd0);
        chk("rst_resp_rdata", resp_rdata[0], 64'd0);
        chk("rst_mem_addr", mem_addr[0], 64'd0);
        chk("rst_mem_wr", 64'(mem_wr[0]), 64'd0);
        chk("rst_mem_wdata", mem_wdata[0], 64'd0);

        preload(0, 5'd2, 64'h8877665544332211);
        preload(1, 5'd2, 64'h8877665544332211);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;

        // MEM_LAT = 1
        issue(0, 0, 2'b00, 0, 64'h17, 0, 1, 0, 64'hffff_ffff_ffff_ff88, 1, -1, 0);
        issue(0, 0, 2'b01, 1, 64'h16, 0, 1, 0, 64'h0000_0000_0000_8877, 1, -1, 0);
        issue(0, 0, 2'b10, 0, 64'h14, 0, 1, 0, 64'hffff_ffff_8877_6655, 1, -1, 0);
        issue(0, 0, 2'b00, 1, 64'h11, 0, 1, 0, 64'h0000_0000_0000_0022, 1, -1, 0);
        issue(0, 1, 2'b00, 0, 64'h13, 64'hab, 1, 0, 64'd0, 2, 1, 64'h8877_6655_ab33_2211);
        issue(0, 0, 2'b11, 0, 64'h10, 0, 1, 0, 64'h8877_6655_ab33_2211, 1, -1, 0);
        issue(0, 1, 2'b11, 0, 64'h20, 64'h0123_4567_89ab_cdef, 1, 0, 64'd0, 1, 0,
              64'h0123_4567_89ab_cdef);
        issue(0, 0, 2'b11, 1, 64'h20, 0, 1, 0, 64'h0123_4567_89ab_cdef, 1, -1, 0);
        issue(0, 0, 2'b10, 0, 64'h22, 0, 1, 1, 64'd0, 0, -1, 0);
        issue(0, 1, 2'b01, 0, 64'h31, 64'h1234, 1, 1, 64'd0, 0, -1, 0);
        issue(0, 1, 2'b01, 0, 64'h24, 64'hbeef, 1, 0, 64'd0, 2, 1, 64'h0123_beef_89ab_cdef);
        issue(0, 0, 2'b01, 0, 64'h24, 0, 1, 0, 64'hffff_ffff_ffff_beef, 1, -1, 0);

        // MEM_LAT = 3: reset during the read phase of a byte store
        issue(1, 1, 2'b00, 0, 64'h13, 64'hab, 0, 0, 64'd0, 0, -1, 0);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        #1;
        chk("abort_mem_wr", 64'(mem_wr[1]), 64'd0);
        chk("abort_req_ready", 64'(req_ready[1]), 64'd1);
        chk("abort_resp_valid", 64'(resp_valid[1]), 64'd0);
        chk("abort_mem_addr", mem_addr[1], 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("release_req_ready", 64'(req_ready[1]), 64'd1);

        // Load while a second request is held during READ: only one response.
        issue(1, 0, 2'b11, 0, 64'h10, 0, 1, 0, 64'h8877_6655_4433_2211, 3, -1, 0);
        req_we[1]    = 1'b1;
        req_size[1]  = 2'b11;
        req_addr[1]  = 64'h10;
        req_wdata[1] = 64'h5555_5555_5555_5555;
        req_valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        issue(1, 0, 2'b10, 0, 64'h14, 0, 1, 0, 64'hffff_ffff_8877_6655, 3, -1, 0);
        issue(1, 1, 2'b10, 0, 64'h10, 64'hcafe_babe, 1, 0, 64'd0, 4, 3,
              64'h8877_6655_cafe_babe);
        issue(1, 0, 2'b00, 1, 64'h12, 0, 1, 0, 64'h0000_0000_0000_00fe, 3, -1, 0);

        repeat (10) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("resp_pending[%0d]", g), 64'(rq[g].size()), 64'd0);
            chk($sformatf("wr_pending[%0d]", g), 64'(wq[g].size()), 64'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
